// File: rtl/fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_sequencer: PC and decode-context registers for the control decoder,   |
// | with a Start/Done program handshake and a saturating RUN-cycle counter.     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module fetch_sequencer #(
  parameter int PC_W       = 10,
  parameter int START_ADDR = 0,
  parameter int CNT_W      = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             BranchEn,
  input  logic [8:0]       BranchTarget,
  input  logic [1:0]       NextState,
  input  logic [8:0]       PrevInstructionIn,
  input  logic             Ack,
  output logic [PC_W-1:0]  ProgCtr,
  output logic [1:0]       CurrState,
  output logic [8:0]       PrevInstruction,
  output logic             Running,
  output logic             Done,
  output logic [CNT_W-1:0] CycleCount
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [PC_W-1:0]  c_start_pc = START_ADDR[PC_W-1:0];
  localparam logic [PC_W-1:0]  c_pc_one   = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_cnt_one  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [1:0]       mode_q, mode_d;
  logic [8:0]       prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PC_W-1:0]  w_branch_pc;

  // Branch targets are 9-bit absolute addresses, zero-extended to the PC width.
  if (PC_W == 9) begin : g_ext_none
    assign w_branch_pc = BranchTarget;
  end else begin : g_ext_zero
    assign w_branch_pc = {{(PC_W-9){1'b0}}, BranchTarget};
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    mode_d  = mode_q;
    prev_d  = prev_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          state_d = S_RUN;
          pc_d    = c_start_pc;
          mode_d  = 2'b00;
          prev_d  = 9'd0;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (cnt_q != c_cnt_max) begin
          cnt_d = cnt_q + c_cnt_one;
        end
        // Ack wins over a simultaneous branch; PC keeps pointing at the Done word.
        if (Ack) begin
          state_d = S_DONE;
          mode_d  = 2'b00;
        end else if (BranchEn) begin
          pc_d   = w_branch_pc;
          mode_d = NextState;
          prev_d = PrevInstructionIn;
        end else begin
          pc_d   = pc_q + c_pc_one;
          mode_d = NextState;
          prev_d = PrevInstructionIn;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q    <= c_start_pc;
      mode_q  <= 2'b00;
      prev_q  <= 9'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mode_q  <= mode_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ProgCtr         = pc_q;
  assign CurrState       = mode_q;
  assign PrevInstruction = prev_q;
  assign CycleCount      = cnt_q;
  assign Running         = (state_q == S_RUN);
  assign Done            = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fetch_sequencer: scoreboard bench for fetch_sequencer, two instances     |
// | (default widths, and PC_W=9/CNT_W=4) against a behavioural model.           |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_fetch_sequencer;

  logic       clk;
  logic       rst;
  logic       start, br_en, ack;
  logic [8:0] br_tgt, prev_in;
  logic [1:0] next_st;

  logic [9:0]  pc_a;
  logic [1:0]  mode_a;
  logic [8:0]  prev_a;
  logic        run_a, done_a;
  logic [15:0] cnt_a;

  logic [8:0]  pc_b;
  logic [1:0]  mode_b;
  logic [8:0]  prev_b;
  logic        run_b, done_b;
  logic [3:0]  cnt_b;

  fetch_sequencer #(.PC_W(10), .START_ADDR(0), .CNT_W(16)) dut (
    .Clk(clk), .Reset(rst), .Start(start), .BranchEn(br_en), .BranchTarget(br_tgt),
    .NextState(next_st), .PrevInstructionIn(prev_in), .Ack(ack),
    .ProgCtr(pc_a), .CurrState(mode_a), .PrevInstruction(prev_a),
    .Running(run_a), .Done(done_a), .CycleCount(cnt_a)
  );

  fetch_sequencer #(.PC_W(9), .START_ADDR(0), .CNT_W(4)) dut_s (
    .Clk(clk), .Reset(rst), .Start(start), .BranchEn(br_en), .BranchTarget(br_tgt),
    .NextState(next_st), .PrevInstructionIn(prev_in), .Ack(ack),
    .ProgCtr(pc_b), .CurrState(mode_b), .PrevInstruction(prev_b),
    .Running(run_b), .Done(done_b), .CycleCount(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  pc10;
    logic [8:0]  pc9;
    logic [1:0]  mode;
    logic [8:0]  prev;
    logic        run;
    logic        done;
    logic [15:0] cnt16;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  // Model: unbounded PC and cycle count, reduced to hardware widths on output.
  int m_phase = 0;  // 0 idle, 1 running, 2 done
  int m_pc = 0, m_mode = 0, m_prev = 0, m_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", name, cyc, act, expv);
    end
  endtask

  task automatic step(input logic rs, input logic st, input logic ak, input logic be,
                      input logic [8:0] tg, input logic [1:0] ns, input logic [8:0] pi);
    exp_t e;
    @(negedge clk);
    rst = rs; start = st; ack = ak; br_en = be; br_tgt = tg; next_st = ns; prev_in = pi;
    @(posedge clk);
    if (rs) begin
      m_phase = 0; m_pc = 0; m_mode = 0; m_prev = 0; m_cnt = 0;
    end else if (m_phase != 1) begin
      if (st) begin
        m_phase = 1; m_pc = 0; m_mode = 0; m_prev = 0; m_cnt = 0;
      end
    end else begin
      m_cnt = m_cnt + 1;
      if (ak) begin
        m_phase = 2; m_mode = 0;
      end else begin
        m_pc   = be ? int'(tg) : m_pc + 1;
        m_mode = int'(ns);
        m_prev = int'(pi);
      end
    end
    e.pc10  = 10'(m_pc % 1024);
    e.pc9   = 9'(m_pc % 512);
    e.mode  = 2'(m_mode);
    e.prev  = 9'(m_prev);
    e.run   = (m_phase == 1);
    e.done  = (m_phase == 2);
    e.cnt16 = 16'((m_cnt > 65535) ? 65535 : m_cnt);
    e.cnt4  = 4'((m_cnt > 15) ? 15 : m_cnt);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 2'b00, 9'(i * 37 + 5));
  endtask

  // Monitor: every cycle the DUTs present registered state; compare against the queue head.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("pc",      32'(pc_a),   32'(e.pc10));
      check("mode",    32'(mode_a), 32'(e.mode));
      check("prev",    32'(prev_a), 32'(e.prev));
      check("running", 32'(run_a),  32'(e.run));
      check("done",    32'(done_a), 32'(e.done));
      check("count",   32'(cnt_a),  32'(e.cnt16));
      check("pc_s",    32'(pc_b),   32'(e.pc9));
      check("mode_s",  32'(mode_b), 32'(e.mode));
      check("prev_s",  32'(prev_b), 32'(e.prev));
      check("run_s",   32'(run_b),  32'(e.run));
      check("done_s",  32'(done_b), 32'(e.done));
      check("count_s", 32'(cnt_b),  32'(e.cnt4));
    end
  end

  initial begin
    int wait_cyc;
    rst = 1'b1; start = 1'b0; ack = 1'b0; br_en = 1'b0;
    br_tgt = '0; next_st = '0; prev_in = '0;

    // Reset, then Start and five sequential fetches.
    step(1'b1, 1'b0, 1'b0, 1'b0, 9'd0, 2'b00, 9'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 9'd0, 2'b00, 9'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 9'd0, 2'b00, 9'd0);
    idle(5);

    // Branch: opcode at PC=3, target word at PC=4.
    step(1'b1, 1'b0, 1'b0, 1'b0, 9'd0, 2'b00, 9'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 9'd0, 2'b00, 9'd0);
    idle(3);
    step(1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 2'b01, 9'h0A5);
    step(1'b0, 1'b0, 1'b0, 1'b1, 9'h1F0, 2'b00, 9'h15A);
    idle(2);

    // Ack priority at PC=7 over a simultaneous branch to 20.
    step(1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 2'b01, 9'h033);
    step(1'b0, 1'b0, 1'b0, 1'b1, 9'd7, 2'b00, 9'h044);
    step(1'b0, 1'b0, 1'b1, 1'b1, 9'd20, 2'b10, 9'h055);
    idle(3);

    // Restart from DONE, then branch to 511 and run until the 10-bit PC wraps.
    step(1'b0, 1'b1, 1'b0, 1'b0, 9'd0, 2'b00, 9'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 9'h1FF, 2'b11, 9'h1FF);
    idle(513);

    // Reset mid-run at PC=12 with CurrState=10 and a pending branch.
    step(1'b0, 1'b0, 1'b0, 1'b1, 9'd12, 2'b10, 9'h0C3);
    step(1'b1, 1'b0, 1'b0, 1'b1, 9'd99, 2'b01, 9'h111);
    idle(3);

    // Saturation of the 4-bit counter after 20 RUN cycles.
    step(1'b0, 1'b1, 1'b0, 1'b0, 9'd0, 2'b00, 9'd0);
    idle(20);

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom % 64) == 0, ($urandom % 6) == 0, ($urandom % 16) == 0,
           ($urandom % 5) == 0, 9'($urandom), 2'($urandom), 9'($urandom));
    end

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain actual=%0d pending expected=0 pending", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
